spislave_io: RTL and testbench

- SPI slave (responder) peripheral: the opposite end of the SPI master already present in the I/O block.
- Lets an external SPI master (e.g. a host MCU) exchange bytes with the 6303 through a small register window in the E6xx I/O space.
- Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- SCK, MOSI and NSS are oversampled on the single system clock; the RX FIFO and TX holding register are CPU-visible.

---
 rtl/spislave_io.sv | 210 +++++++++++++++++++++
 tb/tb_spislave_io.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spislave_io.sv
// SPI slave (responder) for the E6xx I/O window: mode 0, MSB first, 8-bit frames.
// SCK/MOSI/NSS are oversampled on clk, which must run at least 8x SCK.
// Received bytes go into a small RX FIFO, and transmit bytes come from a holding register.
// When the holding register is empty at a load point, the fill byte is sent instead.
// Optional build macro SPISLAVE_IRQ_EN adds the control register and the irq output.
// Without that macro, irq is tied low.
module spislave_io #(
    parameter int         FIFO_AW  = 2,
    parameter logic [7:0] FILL_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       mosi,
    input  logic       nss,
    output logic       miso,
    output logic       miso_oe
);

    localparam int DEPTH = 1 << FIFO_AW;

    // [0] metastable stage, [1] synchronized, [2] history
    logic [2:0] sck_q, mosi_q, nss_q;
    logic       sck_rise, sck_fall, sel, sel_fall, sel_rise, mosi_s;

    logic [2:0] bit_cnt;
    logic       pend;
    logic [6:0] rx_sh;
    logic [7:0] tx_sh, tx_hold, fill, load_val;
    logic       tx_full, ovr, unr;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt;
    logic               rx_ne, rx_full;

    logic tx_wr, st_wr, fill_wr, pop, push, do_push, reload;
    logic [7:0] push_data, status;

    // Synchronizers; reset to the idle bus state (SCK low, NSS high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            mosi_q <= 3'b000;
            nss_q  <= 3'b111;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            mosi_q <= {mosi_q[1:0], mosi};
            nss_q  <= {nss_q[1:0], nss};
        end
    end

    // MOSI is taken from the history stage; it is long stable around an SCK edge.
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign sel      = ~nss_q[1];
    assign sel_fall = ~nss_q[1] & nss_q[2];
    assign sel_rise = nss_q[1] & ~nss_q[2];
    assign mosi_s   = mosi_q[2];

    assign tx_wr   = cs & ~rw & (AD == 2'd0);
    assign st_wr   = cs & ~rw & (AD == 2'd1);
    assign fill_wr = cs & ~rw & (AD == 2'd3);
    assign rx_ne   = (cnt != '0);
    assign rx_full = cnt[FIFO_AW];
    assign pop     = cs & rw & (AD == 2'd0) & rx_ne;

    // Shifter reload points and byte-complete push requests.
    always_comb begin
        reload    = sel_fall | (sel & sck_fall & pend);
        push      = sel & sck_rise & (bit_cnt == 3'd7);
        push_data = {rx_sh, mosi_s};
        load_val  = tx_full ? tx_hold : fill;
        do_push   = push & (~rx_full | pop);
    end

    // Frame engine: bit counter, receive and transmit shifters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            pend    <= 1'b0;
            rx_sh   <= 7'd0;
            tx_sh   <= 8'd0;
        end else if (sel_fall) begin
            bit_cnt <= 3'd0;
            pend    <= 1'b0;
            tx_sh   <= load_val;
        end else if (sel_rise) begin
            bit_cnt <= 3'd0;
            pend    <= 1'b0;
        end else if (sel) begin
            if (sck_rise) begin
                rx_sh <= {rx_sh[5:0], mosi_s};
                if (bit_cnt == 3'd7) begin
                    bit_cnt <= 3'd0;
                    pend    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (sck_fall) begin
                if (pend) begin
                    tx_sh <= load_val;
                    pend  <= 1'b0;
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

    // Holding/fill registers and sticky flags; a flag set beats its clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_hold <= 8'd0;
            tx_full <= 1'b0;
            fill    <= FILL_RST;
            ovr     <= 1'b0;
            unr     <= 1'b0;
        end else begin
            if (tx_wr) begin
                tx_hold <= DI;
                tx_full <= 1'b1;
            end else if (reload && tx_full) begin
                tx_full <= 1'b0;
            end
            if (fill_wr)
                fill <= DI;
            if (reload && !tx_full)
                unr <= 1'b1;
            else if (st_wr && DI[4])
                unr <= 1'b0;
            if (push && rx_full && !pop)
                ovr <= 1'b1;
            else if (st_wr && DI[3])
                ovr <= 1'b0;
        end
    end

    // RX FIFO storage and pointers; a pop of an empty FIFO is already masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign status  = {2'b00, sel, ovr, unr, ~tx_full, rx_full, rx_ne};
    assign miso    = tx_sh[7];
    assign miso_oe = sel;

`ifdef SPISLAVE_IRQ_EN
    logic ie_rx, ie_tx, irq_q;
    logic ctl_wr;
    assign ctl_wr = cs & ~rw & (AD == 2'd2);

    // Control register and registered level interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_rx <= 1'b0;
            ie_tx <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctl_wr) begin
                ie_rx <= DI[0];
                ie_tx <= DI[1];
            end
            irq_q <= (ie_rx & rx_ne) | (ie_tx & ~tx_full) | ovr;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // CPU read mux, combinational from AD.
    always_comb begin
        DO = 8'h00;
        case (AD)
            2'd0: DO = mem[rd_ptr];
            2'd1: DO = status;
`ifdef SPISLAVE_IRQ_EN
            2'd2: DO = {6'b0, ie_tx, ie_rx};
`endif
            2'd3: DO = fill;
            default: DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spislave_io.sv
// Bench for spislave_io: directed scenarios plus randomized frames checked
// against a byte-level behavioural model (queue FIFO, holding/fill choice).
module tb_spislave_io;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] AD;
    logic [7:0] DI, DO;
    logic       rw, cs, irq, sck, mosi, nss, miso, miso_oe;

    int ncmp = 0;
    int nerr = 0;

    // behavioural model state
    logic [7:0] m_fifo[$];
    logic [7:0] m_hold, m_fill, m_cur;
    logic       m_full, m_ovr, m_unr, m_sel, m_ie_rx, m_ie_tx;

    spislave_io dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .irq(irq), .sck(sck), .mosi(mosi), .nss(nss), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {2'b00, m_sel, m_ovr, m_unr, ~m_full,
                (m_fifo.size() == DEPTH), (m_fifo.size() != 0)};
    endfunction

    function automatic logic exp_irq();
`ifdef SPISLAVE_IRQ_EN
        return (m_ie_rx & (m_fifo.size() != 0)) | (m_ie_tx & ~m_full) | m_ovr;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_hold = 8'h00; m_fill = 8'hFF; m_cur = 8'h00;
        m_full = 1'b0; m_ovr = 1'b0; m_unr = 1'b0; m_sel = 1'b0;
        m_ie_rx = 1'b0; m_ie_tx = 1'b0;
    endtask

    // a shifter load: holding byte if one is waiting, else fill (underrun)
    task automatic model_load();
        if (m_full) begin
            m_cur  = m_hold;
            m_full = 1'b0;
        end else begin
            m_cur = m_fill;
            m_unr = 1'b1;
        end
    endtask

    task automatic cpu_wr(input logic [1:0] ad, input logic [7:0] d);
        AD = ad; DI = d; rw = 1'b0; cs = 1'b1;
        tick(1);
        cs = 1'b0;
        case (ad)
            2'd0: begin m_hold = d; m_full = 1'b1; end
            2'd1: begin
                if (d[3]) m_ovr = 1'b0;
                if (d[4]) m_unr = 1'b0;
            end
`ifdef SPISLAVE_IRQ_EN
            2'd2: begin m_ie_rx = d[0]; m_ie_tx = d[1]; end
`endif
            2'd3: m_fill = d;
            default: ;
        endcase
    endtask

    task automatic cpu_rd(input logic [1:0] ad, output logic [7:0] d);
        AD = ad; rw = 1'b1; cs = 1'b1;
        @(negedge clk);
        d = DO;
        tick(1);
        cs = 1'b0;
    endtask

    task automatic chk_status();
        logic [7:0] d;
        cpu_rd(2'd1, d);
        chk("status", d, exp_status());
        chk("irq", {7'b0, irq}, {7'b0, exp_irq()});
    endtask

    task automatic chk_rd_fifo();
        logic [7:0] d;
        cpu_rd(2'd0, d);
        if (m_fifo.size() > 0) begin
            chk("fifo_head", d, m_fifo[0]);
            void'(m_fifo.pop_front());
        end
    endtask

    task automatic spi_begin();
        sck = 1'b0;
        nss = 1'b0;
        m_sel = 1'b1;
        model_load();
        tick(8);
        chk("miso_oe_on", {7'b0, miso_oe}, 8'h01);
    endtask

    // master side of mode 0: data set while SCK low, MISO sampled at the rise
    task automatic spi_byte(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            mosi = b[7-i];
            tick(8);
            chk("miso", {7'b0, miso}, {7'b0, m_cur[7-i]});
            sck = 1'b1;
            tick(8);
            sck = 1'b0;
        end
        if (nb == 8) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
            else m_ovr = 1'b1;
            model_load();
        end
    endtask

    task automatic spi_end();
        tick(8);
        nss = 1'b1;
        m_sel = 1'b0;
        tick(8);
        chk("miso_oe_off", {7'b0, miso_oe}, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        int nb, nr;

        rst = 1'b1; AD = 2'd0; DI = 8'h00; rw = 1'b0; cs = 1'b0;
        sck = 1'b0; mosi = 1'b0; nss = 1'b1;
        model_reset();
        tick(3);

        // reset state
        AD = 2'd3; #1;
        chk("rst_fill", DO, 8'hFF);
        AD = 2'd1; #1;
        chk("rst_status", DO, 8'h04);
        chk("rst_miso", {7'b0, miso}, 8'h00);
        chk("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rst = 1'b0;
        tick(2);

        // holding byte out, one byte in
        cpu_wr(2'd0, 8'hA5);
        spi_begin();
        spi_byte(8'h3C, 8);
        tick(8);
        chk_status();
        spi_end();
        chk_status();
        chk_rd_fifo();

        // overflow: five bytes into a four-deep FIFO
        spi_begin();
        for (int k = 1; k <= 5; k++) spi_byte(8'(k), 8);
        spi_end();
        chk_status();
        for (int k = 0; k < 4; k++) chk_rd_fifo();
        cpu_wr(2'd1, 8'h08);
        chk_status();

        // underrun: fill byte goes out twice
        cpu_wr(2'd3, 8'h5A);
        cpu_wr(2'd1, 8'h18);
        chk_status();
        spi_begin();
        spi_byte(8'($urandom), 8);
        spi_byte(8'($urandom), 8);
        spi_end();
        chk_status();
        chk_rd_fifo();
        chk_rd_fifo();

        // aborted partial byte leaves nothing behind
        spi_begin();
        spi_byte(8'($urandom), 4);
        spi_end();
        chk_status();
        spi_begin();
        spi_byte(8'h81, 8);
        spi_end();
        chk_status();
        chk_rd_fifo();
        chk_status();

        // control register
        cpu_wr(2'd2, 8'h03);
        cpu_rd(2'd2, d);
`ifdef SPISLAVE_IRQ_EN
        chk("ctrl", d, 8'h03);
`else
        chk("ctrl", d, 8'h00);
`endif
        cpu_wr(2'd2, 8'h00);

        // rx interrupt follows FIFO non-empty
        cpu_wr(2'd1, 8'h18);
        cpu_wr(2'd2, 8'h01);
        spi_begin();
        spi_byte(8'($urandom), 8);
        spi_end();
        chk("irq_rx", {7'b0, irq}, {7'b0, exp_irq()});
        chk_rd_fifo();
        tick(1);
        chk("irq_pop", {7'b0, irq}, {7'b0, exp_irq()});
        cpu_wr(2'd2, 8'h00);

        // randomized frames and CPU traffic
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) cpu_wr(2'd0, 8'($urandom));
            if ($urandom_range(0, 3) == 0) cpu_wr(2'd3, 8'($urandom));
            nb = $urandom_range(1, 3);
            spi_begin();
            for (int k = 0; k < nb; k++) spi_byte(8'($urandom), 8);
            spi_end();
            chk_status();
            nr = $urandom_range(0, 3);
            for (int k = 0; k < nr; k++) chk_rd_fifo();
            if ($urandom_range(0, 1) == 1) cpu_wr(2'd1, 8'h18);
            chk_status();
        end

        // reset in the middle of a byte
        cpu_wr(2'd0, 8'($urandom));
        cpu_wr(2'd3, 8'($urandom));
        spi_begin();
        spi_byte(8'($urandom), 4);
        rst = 1'b1;
        tick(2);
        chk("rst_mid_oe", {7'b0, miso_oe}, 8'h00);
        nss = 1'b1; sck = 1'b0; mosi = 1'b0;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(4);
        chk("post_rst_oe", {7'b0, miso_oe}, 8'h00);
        chk("post_rst_miso", {7'b0, miso}, 8'h00);
        chk_status();
        cpu_rd(2'd3, d);
        chk("post_rst_fill", d, 8'hFF);
        spi_begin();
        spi_byte(8'($urandom), 8);
        spi_end();
        chk_status();
        chk_rd_fifo();
        chk_status();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
